ysyx_22050243_id_ctrl: RTL and testbench

Registered, parametrised decode stage for the ysyx_22050243 core. It accepts a fetched instruction over a valid/ready handshake and decodes opcode/funct3/imm[11:0] into the 14-bit control bundle. It classifies illegal, ecall and ebreak instructions and holds the result in an ID/EX pipeline register. It sits between IF and EX, and replaces the combinational decoder plus its DPI-driven ebreak with a halt state machine.

---
 rtl/ysyx_22050243_id_ctrl_if.sv | 30 +++
 rtl/ysyx_22050243_id_ctrl.sv | 159 +++++++++++++++
 tb/tb_ysyx_22050243_id_ctrl.sv | 328 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ysyx_22050243_id_ctrl_if.sv
// ID-stage handshake bundle.
//   IF side : in_valid, in_ready, in_inst, in_pc, flush
//   EX side : out_valid, out_ready, out_pc, out_inst, out_ctrl, out_exc
// master = the environment around the stage (IF producer + EX consumer),
// slave  = the decode stage itself.
interface ysyx_22050243_id_ctrl_if #(
    parameter int XLEN = 64
);
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_inst;
    logic [XLEN-1:0] in_pc;
    logic            flush;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_pc;
    logic [31:0]     out_inst;
    logic [13:0]     out_ctrl;
    logic [1:0]      out_exc;

    modport master (
        output in_valid, in_inst, in_pc, flush, out_ready,
        input  in_ready, out_valid, out_pc, out_inst, out_ctrl, out_exc
    );

    modport slave (
        input  in_valid, in_inst, in_pc, flush, out_ready,
        output in_ready, out_valid, out_pc, out_inst, out_ctrl, out_exc
    );
endinterface

// File: rtl/ysyx_22050243_id_ctrl.sv
// Registered decode stage: accepts an instruction from IF, decodes it into
// the 14-bit control bundle plus an exception class, and holds the result in
// the ID/EX register until EX consumes it. An accepted ebreak drains to EX and
// then freezes the stage until reset.
//
// Ports:
//   clk, rst  - clock, synchronous active-high reset
//   bus       - slave side of the IF/EX handshake bundle
//   halted    - ebreak has retired, stage frozen
//
// out_ctrl = {csr_r, alu_src, mem2reg[2:0], reg_w, mem_r, mem_w, branch,
//             pc_src[1:0], alu_op[2:0]}
// out_exc  = 00 none, 01 illegal, 10 ecall, 11 ebreak
//
// state | meaning
// ------+-----------------------------------------------------------
// RUN   | normal flow, accepts when the ID/EX slot frees up
// DRAIN | ebreak held in ID/EX, waiting for EX to consume it
// HALT  | ebreak retired; no accepts, no output until reset
module ysyx_22050243_id_ctrl #(
    parameter int XLEN   = 64,
    parameter bit CSR_EN = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst,
    ysyx_22050243_id_ctrl_if.slave  bus,
    output logic                    halted
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        HALT  = 2'd2
    } state_t;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_IMM32  = 7'b0011011;
    localparam logic [6:0] OP_REG32  = 7'b0111011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam logic [1:0] EXC_NONE    = 2'b00;
    localparam logic [1:0] EXC_ILLEGAL = 2'b01;
    localparam logic [1:0] EXC_ECALL   = 2'b10;
    localparam logic [1:0] EXC_EBREAK  = 2'b11;

    // Word ops only exist on RV64.
    localparam bit W_OPS_OK = (XLEN != 32);

    state_t      state;
    logic [13:0] dec_ctrl;
    logic [1:0]  dec_exc;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [11:0] imm12;
    logic        accept;

    assign opcode = bus.in_inst[6:0];
    assign funct3 = bus.in_inst[14:12];
    assign imm12  = bus.in_inst[31:20];

    assign bus.in_ready = (!bus.out_valid || bus.out_ready) && (state == RUN);
    assign accept       = bus.in_valid && bus.in_ready;

    always_comb begin
        dec_ctrl = 14'b0;
        dec_exc  = EXC_NONE;
        if (bus.in_inst[1:0] != 2'b11) begin
            dec_exc = EXC_ILLEGAL;
        end else begin
            case (opcode)
                OP_LUI:    dec_ctrl = 14'b0_0_010_1_0_0_0_00_000;
                OP_AUIPC:  dec_ctrl = 14'b0_0_100_1_0_0_0_00_000;
                OP_JAL:    dec_ctrl = 14'b0_0_011_1_0_0_0_01_000;
                OP_JALR:   dec_ctrl = 14'b0_0_011_1_0_0_0_10_000;
                OP_BRANCH: dec_ctrl = 14'b0_0_000_0_0_0_1_00_001;
                OP_LOAD:   dec_ctrl = 14'b0_1_001_1_1_0_0_00_000;
                OP_STORE:  dec_ctrl = 14'b0_1_000_0_0_1_0_00_000;
                OP_IMM:    dec_ctrl = 14'b0_1_000_1_0_0_0_00_011;
                OP_REG:    dec_ctrl = 14'b0_0_000_1_0_0_0_00_010;
                OP_IMM32: begin
                    if (W_OPS_OK) dec_ctrl = 14'b0_1_000_1_0_0_0_00_111;
                    else          dec_exc  = EXC_ILLEGAL;
                end
                OP_REG32: begin
                    if (W_OPS_OK) dec_ctrl = 14'b0_0_000_1_0_0_0_00_110;
                    else          dec_exc  = EXC_ILLEGAL;
                end
                OP_FENCE:  dec_ctrl = 14'b0;
                OP_SYSTEM: begin
                    if (funct3 == 3'b000) begin
                        if (imm12 == 12'h000)      dec_exc = EXC_ECALL;
                        else if (imm12 == 12'h001) dec_exc = EXC_EBREAK;
                        else                       dec_exc = EXC_ILLEGAL;
                    end else if (funct3 == 3'b100 || !CSR_EN) begin
                        dec_exc = EXC_ILLEGAL;
                    end else begin
                        dec_ctrl = 14'b1_0_101_1_0_0_0_00_000;
                    end
                end
                default:   dec_exc = EXC_ILLEGAL;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= RUN;
            halted        <= 1'b0;
            bus.out_valid <= 1'b0;
            bus.out_pc    <= '0;
            bus.out_inst  <= 32'b0;
            bus.out_ctrl  <= 14'b0;
            bus.out_exc   <= EXC_NONE;
        end else begin
            case (state)
                RUN: begin
                    // flush wins over a same-cycle accept: the payload is not
                    // even loaded, so the register keeps its last entry.
                    if (bus.flush) begin
                        bus.out_valid <= 1'b0;
                    end else if (accept) begin
                        bus.out_valid <= 1'b1;
                        bus.out_pc    <= bus.in_pc;
                        bus.out_inst  <= bus.in_inst;
                        bus.out_ctrl  <= dec_ctrl;
                        bus.out_exc   <= dec_exc;
                        if (dec_exc == EXC_EBREAK) state <= DRAIN;
                    end else if (bus.out_ready) begin
                        bus.out_valid <= 1'b0;
                    end
                end
                DRAIN: begin
                    if (bus.flush) begin
                        bus.out_valid <= 1'b0;
                        state         <= RUN;
                    end else if (bus.out_valid && bus.out_ready) begin
                        bus.out_valid <= 1'b0;
                        halted        <= 1'b1;
                        state         <= HALT;
                    end
                end
                default: begin
                    bus.out_valid <= 1'b0;
                    halted        <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_22050243_id_ctrl.sv
module tb_ysyx_22050243_id_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic halted_a, halted_b;
    int   n_chk = 0;
    int   n_err = 0;
    bit   armed = 1'b0;

    always #5 clk = ~clk;

    ysyx_22050243_id_ctrl_if #(.XLEN(64)) ifa ();
    ysyx_22050243_id_ctrl_if #(.XLEN(32)) ifb ();

    ysyx_22050243_id_ctrl #(.XLEN(64), .CSR_EN(1'b1)) dut_a (
        .clk(clk), .rst(rst), .bus(ifa.slave), .halted(halted_a)
    );
    ysyx_22050243_id_ctrl #(.XLEN(32), .CSR_EN(1'b0)) dut_b (
        .clk(clk), .rst(rst), .bus(ifb.slave), .halted(halted_b)
    );

    localparam logic [31:0] I_ADDI   = 32'h00100093;
    localparam logic [31:0] I_LW     = 32'h0000a103;
    localparam logic [31:0] I_JAL    = 32'h008000ef;
    localparam logic [31:0] I_ADDIW  = 32'h0010009b;
    localparam logic [31:0] I_ADDW   = 32'h0020803b;
    localparam logic [31:0] I_CSRRW  = 32'h30529073;
    localparam logic [31:0] I_ECALL  = 32'h00000073;
    localparam logic [31:0] I_EBREAK = 32'h00100073;
    localparam logic [31:0] I_SYS100 = 32'h30524073;
    localparam logic [31:0] I_SYSBAD = 32'h00200073;

    // ---------------- reference model ----------------
    // mode: 0 run, 1 waiting for ebreak to leave, 2 halted
    typedef struct packed {
        logic        v;
        logic [63:0] pc;
        logic [31:0] inst;
        logic [15:0] dec;   // {ctrl, exc}
        logic [1:0]  mode;
    } ms_t;

    ms_t m_a = '0;
    ms_t m_b = '0;

    function automatic logic [15:0] ref_decode(logic [31:0] w, int xlen, bit csr_en);
        logic [15:0] ill;
        logic [2:0]  f3;
        logic [11:0] imm;
        ill = 16'b01;
        f3  = w[14:12];
        imm = w[31:20];
        if (w[1:0] != 2'b11) return ill;
        case (w[6:0])
            7'b0110111: return {14'b0_0_010_1_0_0_0_00_000, 2'b00};
            7'b0010111: return {14'b0_0_100_1_0_0_0_00_000, 2'b00};
            7'b1101111: return {14'b0_0_011_1_0_0_0_01_000, 2'b00};
            7'b1100111: return {14'b0_0_011_1_0_0_0_10_000, 2'b00};
            7'b1100011: return {14'b0_0_000_0_0_0_1_00_001, 2'b00};
            7'b0000011: return {14'b0_1_001_1_1_0_0_00_000, 2'b00};
            7'b0100011: return {14'b0_1_000_0_0_1_0_00_000, 2'b00};
            7'b0010011: return {14'b0_1_000_1_0_0_0_00_011, 2'b00};
            7'b0110011: return {14'b0_0_000_1_0_0_0_00_010, 2'b00};
            7'b0011011: return (xlen == 32) ? ill : {14'b0_1_000_1_0_0_0_00_111, 2'b00};
            7'b0111011: return (xlen == 32) ? ill : {14'b0_0_000_1_0_0_0_00_110, 2'b00};
            7'b0001111: return 16'b0;
            7'b1110011: begin
                if (f3 == 3'b000) begin
                    if (imm == 12'h000) return 16'b10;
                    if (imm == 12'h001) return 16'b11;
                    return ill;
                end
                if (f3 == 3'b100 || !csr_en) return ill;
                return {14'b1_0_101_1_0_0_0_00_000, 2'b00};
            end
            default: return ill;
        endcase
    endfunction

    function automatic bit exp_rdy(ms_t s, bit ordy);
        return (!s.v || ordy) && (s.mode == 2'd0);
    endfunction

    function automatic ms_t mstep(ms_t s, bit r, bit iv, logic [31:0] w, logic [63:0] pc,
                                  bit fl, bit ordy, int xlen, bit csr_en);
        ms_t n;
        bit  consumed;
        n = s;
        if (r) return '0;
        consumed = s.v && ordy;
        if (s.mode == 2'd2) begin
            n.v = 1'b0;
        end else if (fl) begin
            n.v    = 1'b0;
            n.mode = 2'd0;
        end else if (iv && exp_rdy(s, ordy)) begin
            n.v    = 1'b1;
            n.pc   = pc;
            n.inst = w;
            n.dec  = ref_decode(w, xlen, csr_en);
            if (n.dec[1:0] == 2'b11) n.mode = 2'd1;
        end else if (consumed) begin
            n.v = 1'b0;
            if (s.mode == 2'd1) n.mode = 2'd2;
        end
        return n;
    endfunction

    always @(posedge clk) begin
        m_a = mstep(m_a, rst, ifa.in_valid, ifa.in_inst, ifa.in_pc, ifa.flush,
                    ifa.out_ready, 64, 1'b1);
        m_b = mstep(m_b, rst, ifb.in_valid, ifb.in_inst, {32'b0, ifb.in_pc}, ifb.flush,
                    ifb.out_ready, 32, 1'b0);
    end

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%h expected=%h at %0t", nm, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (armed) begin
            chk("a_in_ready", ifa.in_ready, exp_rdy(m_a, ifa.out_ready));
            chk("a_out_valid", ifa.out_valid, m_a.v);
            chk("a_halted", halted_a, m_a.mode == 2'd2);
            if (m_a.v) begin
                chk("a_out_pc", ifa.out_pc, m_a.pc);
                chk("a_out_inst", ifa.out_inst, m_a.inst);
                chk("a_out_ctrl", ifa.out_ctrl, m_a.dec[15:2]);
                chk("a_out_exc", ifa.out_exc, m_a.dec[1:0]);
            end
            chk("b_in_ready", ifb.in_ready, exp_rdy(m_b, ifb.out_ready));
            chk("b_out_valid", ifb.out_valid, m_b.v);
            chk("b_halted", halted_b, m_b.mode == 2'd2);
            if (m_b.v) begin
                chk("b_out_pc", {32'b0, ifb.out_pc}, m_b.pc);
                chk("b_out_inst", ifb.out_inst, m_b.inst);
                chk("b_out_ctrl", ifb.out_ctrl, m_b.dec[15:2]);
                chk("b_out_exc", ifb.out_exc, m_b.dec[1:0]);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_a(input bit v, input logic [31:0] w, input logic [63:0] pc);
        ifa.in_valid = v;
        ifa.in_inst  = w;
        ifa.in_pc    = pc;
    endtask

    task automatic drive_b(input bit v, input logic [31:0] w, input logic [31:0] pc);
        ifb.in_valid = v;
        ifb.in_inst  = w;
        ifb.in_pc    = pc;
    endtask

    initial begin
        drive_a(1'b0, 32'b0, 64'b0);
        drive_b(1'b0, 32'b0, 32'b0);
        ifa.flush = 1'b0; ifa.out_ready = 1'b0;
        ifb.flush = 1'b0; ifb.out_ready = 1'b0;
        rst = 1'b1;
        step();
        step();
        armed = 1'b1;
        chk("rst_in_ready", ifa.in_ready, 1'b1);
        chk("rst_out_valid", ifa.out_valid, 1'b0);
        chk("rst_halted", halted_a, 1'b0);
        chk("rst_out_pc", ifa.out_pc, 64'h0);
        chk("rst_out_ctrl", ifa.out_ctrl, 14'h0);
        chk("rst_out_exc", ifa.out_exc, 2'b00);
        rst = 1'b0;

        // back-to-back stream
        ifa.out_ready = 1'b1;
        drive_a(1'b1, I_ADDI, 64'h8000_0000);
        step();
        chk("addi_ctrl", ifa.out_ctrl, 14'b0_1_000_1_0_0_0_00_011);
        chk("addi_exc", ifa.out_exc, 2'b00);
        drive_a(1'b1, I_LW, 64'h8000_0004);
        step();
        chk("lw_ctrl", ifa.out_ctrl, 14'b0_1_001_1_1_0_0_00_000);
        chk("lw_valid", ifa.out_valid, 1'b1);
        drive_a(1'b1, I_JAL, 64'h8000_0008);
        step();
        chk("jal_ctrl", ifa.out_ctrl, 14'b0_0_011_1_0_0_0_01_000);
        chk("jal_pc", ifa.out_pc, 64'h8000_0008);
        drive_a(1'b0, 32'b0, 64'b0);
        step();
        chk("stream_drained", ifa.out_valid, 1'b0);

        // backpressure
        ifa.out_ready = 1'b0;
        drive_a(1'b1, I_ADDI, 64'h100);
        step();
        drive_a(1'b1, I_LW, 64'h104);
        for (int i = 0; i < 3; i++) begin
            chk("bp_in_ready", ifa.in_ready, 1'b0);
            chk("bp_hold_inst", ifa.out_inst, I_ADDI);
            step();
        end
        ifa.out_ready = 1'b1;
        #1;
        chk("bp_release_ready", ifa.in_ready, 1'b1);
        step();
        chk("bp_second_inst", ifa.out_inst, I_LW);
        chk("bp_second_pc", ifa.out_pc, 64'h104);
        drive_a(1'b0, 32'b0, 64'b0);
        step();

        // decode corners on the RV64/CSR build
        drive_a(1'b1, 32'h0000_0000, 64'h200);
        step();
        chk("zero_exc", ifa.out_exc, 2'b01);
        chk("zero_ctrl", ifa.out_ctrl, 14'b0);
        drive_a(1'b1, I_ADDIW, 64'h204);
        step();
        chk("addiw64_ctrl", ifa.out_ctrl, 14'b0_1_000_1_0_0_0_00_111);
        chk("addiw64_exc", ifa.out_exc, 2'b00);
        drive_a(1'b1, I_CSRRW, 64'h208);
        step();
        chk("csrrw_ctrl", ifa.out_ctrl, 14'b1_0_101_1_0_0_0_00_000);
        drive_a(1'b1, I_ECALL, 64'h20c);
        step();
        chk("ecall_exc", ifa.out_exc, 2'b10);
        drive_a(1'b1, I_SYS100, 64'h210);
        step();
        drive_a(1'b1, I_SYSBAD, 64'h214);
        step();
        chk("sys_bad_imm_exc", ifa.out_exc, 2'b01);
        drive_a(1'b1, I_ADDW, 64'h218);
        step();
        drive_a(1'b0, 32'b0, 64'b0);
        step();

        // flush of a held ebreak
        ifa.out_ready = 1'b0;
        drive_a(1'b1, I_EBREAK, 64'h300);
        step();
        chk("ebrk_exc", ifa.out_exc, 2'b11);
        chk("ebrk_in_ready", ifa.in_ready, 1'b0);
        drive_a(1'b0, 32'b0, 64'b0);
        ifa.flush = 1'b1;
        step();
        ifa.flush = 1'b0;
        chk("flush_valid", ifa.out_valid, 1'b0);
        chk("flush_halted", halted_a, 1'b0);
        chk("flush_run_ready", ifa.in_ready, 1'b1);

        // flush beats a same-cycle accept
        ifa.out_ready = 1'b1;
        drive_a(1'b1, I_ADDI, 64'h400);
        ifa.flush = 1'b1;
        step();
        ifa.flush = 1'b0;
        chk("flush_acc_valid", ifa.out_valid, 1'b0);
        drive_a(1'b0, 32'b0, 64'b0);
        step();

        // ebreak retires and freezes the stage
        drive_a(1'b1, I_EBREAK, 64'h500);
        step();
        chk("halt_ebrk_exc", ifa.out_exc, 2'b11);
        drive_a(1'b1, I_ADDI, 64'h504);
        #1;
        chk("halt_drain_ready", ifa.in_ready, 1'b0);
        step();
        chk("halt_set", halted_a, 1'b1);
        chk("halt_valid", ifa.out_valid, 1'b0);
        repeat (3) step();
        chk("halt_stays", halted_a, 1'b1);
        chk("halt_no_accept", ifa.out_inst, I_EBREAK);
        rst = 1'b1;
        step();
        rst = 1'b0;
        drive_a(1'b0, 32'b0, 64'b0);
        chk("halt_rst_clear", halted_a, 1'b0);
        chk("halt_rst_ready", ifa.in_ready, 1'b1);
        step();

        // reset in the middle of a drain
        ifa.out_ready = 1'b0;
        drive_a(1'b1, I_EBREAK, 64'h600);
        step();
        drive_a(1'b0, 32'b0, 64'b0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("drain_rst_ready", ifa.in_ready, 1'b1);
        chk("drain_rst_valid", ifa.out_valid, 1'b0);
        step();

        // RV32 build without CSRs
        ifb.out_ready = 1'b1;
        drive_b(1'b1, 32'h0000_0000, 32'h1000);
        step();
        chk("b_zero_exc", ifb.out_exc, 2'b01);
        drive_b(1'b1, I_ADDIW, 32'h1004);
        step();
        chk("b_addiw_exc", ifb.out_exc, 2'b01);
        chk("b_addiw_ctrl", ifb.out_ctrl, 14'b0);
        drive_b(1'b1, I_ADDW, 32'h1008);
        step();
        drive_b(1'b1, I_CSRRW, 32'h100c);
        step();
        chk("b_csrrw_exc", ifb.out_exc, 2'b01);
        drive_b(1'b1, I_ADDI, 32'h1010);
        step();
        chk("b_addi_ctrl", ifb.out_ctrl, 14'b0_1_000_1_0_0_0_00_011);
        drive_b(1'b1, I_ECALL, 32'h1014);
        step();
        drive_b(1'b0, 32'b0, 32'b0);
        step();
        step();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
